// File: rtl/fall_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fall_detect_pkg
// Purpose  : Shared types and constants for the windowed fall detector.
// Revision : 1.0 - initial release
// ============================================================================
package fall_detect_pkg;

    // Window controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DECIDE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Beat classification: any channel out of band, or all channels out of band
    localparam logic MODE_ANY = 1'b0;
    localparam logic MODE_ALL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fall_range_cmp.sv
`default_nettype none
// ============================================================================
// Module   : fall_range_cmp
// Purpose  : Single-channel out-of-band flag against an inclusive band.
// Revision : 1.0 - initial release
// ============================================================================
module fall_range_cmp #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] ch,
    input  logic [DATA_W-1:0] lower_limit,
    input  logic [DATA_W-1:0] upper_limit,
    output logic              out_of_band
);

    // Both bounds count as out of band; an inverted/empty band flags everything
    always_comb begin
        out_of_band = (lower_limit >= upper_limit) ||
                      (ch <= lower_limit)          ||
                      (ch >= upper_limit);
    end

endmodule
`default_nettype wire

// File: rtl/fall_detect_window.sv
`default_nettype none
// ============================================================================
// Module   : fall_detect_window
// Purpose  : Counts out-of-band accelerometer beats over a fixed window,
//            decides fall / no-fall, pulses done and drives a latched,
//            active-low LED alarm with a minimum hold time.
// Revision : 1.0 - initial release
// ============================================================================
module fall_detect_window
    import fall_detect_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int NUM_CH      = 3,
    parameter int WIN_LEN     = 32,
    parameter int HIT_THRESH  = 2,
    parameter int DONE_CYCLES = 5,
    parameter int ALARM_HOLD  = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [NUM_CH*DATA_W-1:0]     s_data,
    input  logic [DATA_W-1:0]            lower_limit,
    input  logic [DATA_W-1:0]            upper_limit,
    input  logic                         mode,
    input  logic                         alarm_clr,
    output logic                         done,
    output logic                         alarm_n,
    output logic [$clog2(WIN_LEN+1)-1:0] hit_count
);

    localparam int CNT_W  = $clog2(WIN_LEN + 1);
    localparam int DCNT_W = $clog2(DONE_CYCLES + 1);
    localparam int HOLD_W = $clog2(ALARM_HOLD + 1);

    localparam logic [CNT_W-1:0]  C_BEAT_LAST = CNT_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0]  C_HIT_MAX   = CNT_W'(WIN_LEN);
    localparam logic [CNT_W-1:0]  C_HIT_THR   = CNT_W'(HIT_THRESH);
    localparam logic [DCNT_W-1:0] C_DONE_LAST = DCNT_W'(DONE_CYCLES);
    localparam logic [HOLD_W-1:0] C_HOLD      = HOLD_W'(ALARM_HOLD);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_beat_idx;
    logic [DCNT_W-1:0]   r_done_cnt;
    logic [HOLD_W-1:0]   r_hold;
    logic                r_alarm_latch;
    logic [NUM_CH-1:0]   w_ch_oob;
    logic                w_beat_hit;
    logic                w_accept;
    logic                w_fall;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        fall_range_cmp #(
            .DATA_W (DATA_W)
        ) u_cmp (
            .ch          (s_data[c*DATA_W +: DATA_W]),
            .lower_limit (lower_limit),
            .upper_limit (upper_limit),
            .out_of_band (w_ch_oob[c])
        );
    end

    // Beat classification and handshake / decision qualifiers
    always_comb begin
        w_beat_hit = (mode == MODE_ANY) ? (|w_ch_oob) : (&w_ch_oob);
        w_accept   = s_valid && s_ready;
        w_fall     = (r_state == DECIDE) && (hit_count >= C_HIT_THR);
    end

    // Next-state logic; dropping start aborts a window without a decision
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = COLLECT;
            end
            COLLECT: begin
                if (!start)
                    w_state_nxt = IDLE;
                else if (w_accept && (r_beat_idx == C_BEAT_LAST))
                    w_state_nxt = DECIDE;
            end
            DECIDE: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                if (r_done_cnt == C_DONE_LAST) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register with registered ready derived from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            s_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            s_ready <= (w_state_nxt == COLLECT);
        end
    end

    // Beat index and hit counter; an abort edge discards any beat on that edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_idx <= '0;
            hit_count  <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_beat_idx <= '0;
            hit_count  <= '0;
        end else if ((r_state == COLLECT) && start && w_accept) begin
            r_beat_idx <= r_beat_idx + CNT_W'(1);
            if (w_beat_hit && (hit_count != C_HIT_MAX))
                hit_count <= hit_count + CNT_W'(1);
        end
    end

    // done is registered from the DONE state, so it trails the state by a cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_cnt <= '0;
            done       <= 1'b0;
        end else begin
            done <= (r_state == DONE) && (r_done_cnt < C_DONE_LAST);
            if (r_state == DECIDE)
                r_done_cnt <= '0;
            else if ((r_state == DONE) && (r_done_cnt != C_DONE_LAST))
                r_done_cnt <= r_done_cnt + DCNT_W'(1);
        end
    end

    // Alarm latch and hold timer; a fresh fall beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold        <= '0;
            r_alarm_latch <= 1'b0;
            alarm_n       <= 1'b1;
        end else begin
            alarm_n <= ~r_alarm_latch;
            if (w_fall) begin
                r_alarm_latch <= 1'b1;
                r_hold        <= C_HOLD;
            end else begin
                if (r_hold != '0)
                    r_hold <= r_hold - HOLD_W'(1);
                if ((r_hold == '0) && alarm_clr)
                    r_alarm_latch <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
